dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the core load/store path (port 0) and a loader/DMA port (port 1). It drives the memory's address, write-data and write-enable lines from the winning requester. It registers the read data into a one-cycle response. It also range-checks word addresses against the memory depth.

## Interface
- DEPTH, 85, number of 32-bit words in the data memory; valid word addresses are 0..DEPTH-1
- MAX_WAIT, 4, consecutive denied cycles after which port 1 overrides port 0 (1..15)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  port request; must stay high until the port's gnt
- we0 / we1  in  1  1 = write, 0 = read; must be stable while req is high
- addr0 / addr1  in  32  word address; must be stable while req is high
- wdata0 / wdata1  in  32  write data; must be stable while req is high
- gnt0 / gnt1  out  1  combinational; the request is accepted this cycle
- rvalid0 / rvalid1  out  1  registered one-cycle response strobe
- rdata0 / rdata1  out  32  registered read data; 0 for writes and errors
- err0 / err1  out  1  registered; the accepted address was ≥ DEPTH
- mem_A  out  32  memory address
- mem_WD  out  32  memory write data
- mem_WE  out  1  memory write enable
- mem_RD  in  32  memory read data; combinational from mem_A

## Operation
- At most one grant per cycle. gnt0 and gnt1 are never high together.
- Selection:
  - Only one req high: that port wins.
  - Both high: port 0 wins, unless wait_cnt == MAX_WAIT, in which case port 1 wins.
- wait_cnt is a 4-bit register.
  - Increments when req1 is high and gnt1 is low; saturates at MAX_WAIT.
  - Clears to 0 when gnt1 is high or req1 is low.
- Memory drive in a granted cycle:
  - mem_A = winner's addr.
  - mem_WD = winner's wdata.
  - mem_WE = winner's we AND (addr < DEPTH).
- Memory drive with no grant: mem_A = 0, mem_WD = 0, mem_WE = 0.
- Out-of-range access (addr ≥ DEPTH, full 32-bit compare):
  - Still granted.
  - mem_WE forced to 0 and mem_A forced to 0.
  - Memory contents are never modified.
- Response: every granted transaction, read or write, produces exactly one response on the winning port in the next cycle.
  - rvalid = 1.
  - err = out-of-range flag.
  - rdata = mem_RD sampled at the grant edge for an in-range read, else 0.
- The response register for the non-granted port gets rvalid = 0, err = 0, rdata = 0.
- The arbiter is fully pipelined: a port may be granted again in the cycle its previous response is visible.

## Timing
- Reset values (rst_n low, asynchronous):
  - rvalid0/1 = 0, err0/1 = 0, rdata0/1 = 0.
  - wait_cnt = 0.
  - gnt0/1, mem_WE, mem_A, mem_WD follow the combinational rules.
- While rst_n is low, all gnt and mem_WE are forced to 0.
- Latency:
  - Grant is same-cycle as the request when the port wins.
  - A write commits at the rising edge ending the grant cycle.
  - The response is valid for exactly the one following cycle.
- Read-after-write: a port-1 read of an address written by port 0 in the previous cycle returns the new data, because the write has committed before the read's grant edge.
- Starvation bound: with req0 held high continuously, port 1 is granted no later than cycle MAX_WAIT+1 after raising req1.
- Reset mid-operation:
  - A pending response is dropped; rvalid goes low immediately.
  - A write in flight at the asserting edge is not guaranteed to commit.
- Requests must not change while req is high and gnt is low. Behaviour under such changes is undefined and is not checked.

## Test plan
- Reset: hold rst_n = 0 with req0 = req1 = 1 → gnt0 = gnt1 = 0, mem_WE = 0, all rvalid/err/rdata = 0. Release → gnt0 = 1 in that same cycle.
- Single-port write then read on port 0:
  - Write addr 5, wdata 32'hDEADBEEF → gnt0 = 1, mem_WE = 1 that cycle; next cycle rvalid0 = 1, rdata0 = 0, err0 = 0.
  - Read addr 5 → next cycle rvalid0 = 1, rdata0 = 32'hDEADBEEF.
- Contention: req0 and req1 held high (reads) with MAX_WAIT = 4 → gnt0 for 4 cycles, gnt1 on the 5th, then gnt0. wait_cnt returns to 0 after gnt1.
- Out-of-range:
  - Port 1 writes addr 85, data 32'h12345678 → gnt1 = 1, mem_WE = 0; next cycle err1 = 1, rvalid1 = 1.
  - Subsequent read of addr 0 returns its prior value unchanged.
- Read-after-write across ports: port 0 writes addr 10 = 32'hA5A5A5A5 in cycle N; port 1 reads addr 10 in cycle N+1 → rdata1 = 32'hA5A5A5A5 in cycle N+2.
- Async reset mid-transaction: assert rst_n low between edges while rvalid1 = 1 → rvalid1 = 0 and rdata1 = 0 without waiting for clk; wait_cnt = 0 after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: the core load/store path (port 0) and a
// loader/DMA port (port 1) share one single-port memory. Port 0 has priority
// until port 1 has been denied MAX_WAIT consecutive cycles. Every accepted
// request, read or write, gets exactly one registered response strobe in the
// following cycle on its own port. Addresses at or beyond DEPTH are accepted
// but flagged as errors and never touch the memory.
//
// Handshake: a port raises reqN and holds weN/addrN/wdataN stable until gntN
// is seen high at a rising edge. gntN is combinational and means "accepted
// this cycle". The response (rvalidN/errN/rdataN) is valid for exactly the
// next cycle and cannot be back-pressured.
module dmem_arbiter #(
    parameter int DEPTH    = 85,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD,
    output logic [3:0]  dbg_wait_cnt
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  MAX_W   = 4'(MAX_WAIT);

    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic        sel1;
    logic        any_gnt;
    logic        win_we;
    logic        win_in_range;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [31:0] rsp_rdata;

    // Arbitration, memory drive and next-state for the response registers.
    always_comb begin
        sel1 = req1 && (!req0 || (wait_cnt_q == MAX_W));
        gnt1 = rst_n && sel1;
        gnt0 = rst_n && req0 && !sel1;
        any_gnt = gnt0 || gnt1;

        win_addr  = gnt1 ? addr1  : addr0;
        win_wdata = gnt1 ? wdata1 : wdata0;
        win_we    = gnt1 ? we1    : we0;
        win_in_range = (win_addr < DEPTH_W);

        // Out-of-range accesses park the address at 0 so the memory never
        // sees an index beyond its depth.
        mem_A  = (any_gnt && win_in_range) ? win_addr : 32'd0;
        mem_WD = any_gnt ? win_wdata : 32'd0;
        mem_WE = any_gnt && win_we && win_in_range;

        rsp_rdata = (win_in_range && !win_we) ? mem_RD : 32'd0;

        rvalid0_d = gnt0;
        err0_d    = gnt0 && !win_in_range;
        rdata0_d  = gnt0 ? rsp_rdata : 32'd0;
        rvalid1_d = gnt1;
        err1_d    = gnt1 && !win_in_range;
        rdata1_d  = gnt1 ? rsp_rdata : 32'd0;

        // Count consecutive denied cycles of port 1, saturating at MAX_WAIT.
        if (req1 && !gnt1) begin
            wait_cnt_d = (wait_cnt_q == MAX_W) ? MAX_W : wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = 4'd0;
        end
    end

    // Response registers and the port-1 wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 4'd0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= 32'd0;
            rdata1_q   <= 32'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign err0         = err0_q;
    assign err1         = err1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign dbg_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus two concurrent random
// request streams, with a reference model predicting grants, memory drive
// and responses, and a monitor checking every response against a queue.
module tb_dmem_arbiter;

  localparam int DEPTH    = 85;
  localparam int MAX_WAIT = 4;
  localparam int EW       = 65; // {due_cycle[31:0], err, rdata[31:0]}

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;
  logic [3:0]  dbg_wait_cnt;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp1_q[$];

  dmem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD),
    .dbg_wait_cnt(dbg_wait_cnt)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responses pending at a reset assertion are dropped by the design.
  always @(negedge rst_n) begin
    exp0_q.delete();
    exp1_q.delete();
  end

  // ---------------- memory harness ----------------
  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  logic [31:0] hmem[DEPTH];
  logic        written[DEPTH];

  always @(posedge clk) begin
    if (mem_WE && mem_A < DEPTH) begin
      hmem[mem_A]    <= mem_WD;
      written[mem_A] <= 1'b1;
    end
  end

  always_comb begin
    mem_RD = 32'd0;
    if (mem_A < DEPTH) begin
      mem_RD = (written[mem_A] === 1'b1) ? hmem[mem_A] : init_word(int'(mem_A));
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Port 1 wins when alone, or once it has been refused MAX_WAIT cycles in a
  // row; otherwise port 0 has priority. Memory content is a plain array.
  logic [31:0] mdl[DEPTH];
  int denied1;

  initial begin
    logic e0, e1, w_we, inr;
    logic [31:0] w_a, w_d, rd;
    for (int i = 0; i < DEPTH; i++) mdl[i] = init_word(i);
    denied1 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        denied1 = 0;
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_WE}, 32'd0);
      end else begin
        e1 = req1 && (!req0 || denied1 >= MAX_WAIT);
        e0 = req0 && !e1;
        chk("gnt0", {31'd0, gnt0}, {31'd0, e0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, e1});
        chk("wait_cnt", {28'd0, dbg_wait_cnt}, 32'(denied1));
        if (e0 || e1) begin
          w_a  = e1 ? addr1 : addr0;
          w_d  = e1 ? wdata1 : wdata0;
          w_we = e1 ? we1 : we0;
          inr  = (w_a < DEPTH);
          chk("mem_A", mem_A, inr ? w_a : 32'd0);
          chk("mem_WD", mem_WD, w_d);
          chk("mem_WE", {31'd0, mem_WE}, {31'd0, w_we && inr});
          rd = 32'd0;
          if (inr && !w_we) rd = mdl[w_a];
          if (inr && w_we) mdl[w_a] = w_d;
          if (e0) exp0_q.push_back({32'(cyc + 1), !inr, rd});
          else    exp1_q.push_back({32'(cyc + 1), !inr, rd});
        end else begin
          chk("idle_mem_A", mem_A, 32'd0);
          chk("idle_mem_WD", mem_WD, 32'd0);
          chk("idle_mem_WE", {31'd0, mem_WE}, 32'd0);
        end
        if (req1 && !e1) denied1 = (denied1 >= MAX_WAIT) ? MAX_WAIT : denied1 + 1;
        else             denied1 = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic mon_port(input int p, input logic rv, input logic er, input logic [31:0] rd);
    logic [EW-1:0] e;
    logic has;
    has = (p == 0) ? (exp0_q.size() > 0) : (exp1_q.size() > 0);
    if (has) e = (p == 0) ? exp0_q[0] : exp1_q[0];
    if (has && e[64:33] == 32'(cyc)) begin
      if (p == 0) void'(exp0_q.pop_front());
      else        void'(exp1_q.pop_front());
      chk((p == 0) ? "rvalid0" : "rvalid1", {31'd0, rv}, 32'd1);
      chk((p == 0) ? "err0" : "err1", {31'd0, er}, {31'd0, e[32]});
      chk((p == 0) ? "rdata0" : "rdata1", rd, e[31:0]);
    end else if (rv) begin
      checks++;
      fails++;
      $display("FAIL unexpected_rvalid%0d: actual=1 required=0 (cycle %0d)", p, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon_port(0, rvalid0, err0, rdata0);
        mon_port(1, rvalid1, err1, rdata1);
        if (gnt0 && gnt1) begin
          checks++;
          fails++;
          $display("FAIL dual_grant: actual=11 required=not both (cycle %0d)", cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; return just after the edge that
  // accepted the request.
  task automatic p0_xfer(input logic we, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    @(negedge clk);
    while (gnt0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (gnt0 !== 1'b1) begin
      checks++; fails++;
      $display("FAIL p0_grant_timeout: actual=no grant required=grant within 20 cycles");
    end
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  task automatic p1_xfer(input logic we, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    @(negedge clk);
    while (gnt1 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (gnt1 !== 1'b1) begin
      checks++; fails++;
      $display("FAIL p1_grant_timeout: actual=no grant required=grant within 20 cycles");
    end
    @(posedge clk); #1;
    req1 = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    int k = $urandom_range(0, 9);
    if (k == 0) return 32'(DEPTH);
    if (k == 1) return 32'(DEPTH - 1);
    if (k == 2) return $urandom;
    return 32'($urandom_range(0, DEPTH - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd1; wdata0 = 32'd0; wdata1 = 32'd0;

    // Reset with both requests high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("rst_err", {30'd0, err1, err0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_gnt0", {31'd0, gnt0}, 32'd1);
    @(posedge clk); #1; req0 = 1'b0;
    @(posedge clk); #1; req1 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Port 0 write then read of address 5
    p0_xfer(1'b1, 32'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_rsp_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("wr_rsp_rdata0", rdata0, 32'd0);
    chk("wr_rsp_err0", {31'd0, err0}, 32'd0);
    @(posedge clk); #1;
    p0_xfer(1'b0, 32'd5, 32'd0);
    @(negedge clk);
    chk("rd5_rdata0", rdata0, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Contention: port 0 back-to-back reads against one port 1 read
    fork
      for (int i = 0; i < 6; i++) p0_xfer(1'b0, 32'(i), 32'd0);
      p1_xfer(1'b0, 32'd7, 32'd0);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        chk("contend_gnt1", {31'd0, gnt1}, {31'd0, c == MAX_WAIT});
        chk("contend_gnt0", {31'd0, gnt0}, {31'd0, c != MAX_WAIT});
      end
    join
    @(negedge clk);
    chk("contend_wait_clear", {28'd0, dbg_wait_cnt}, 32'd0);
    @(posedge clk); #1;

    // Out-of-range write on port 1, then address 0 must be untouched
    p1_xfer(1'b1, 32'd85, 32'h12345678);
    @(negedge clk);
    chk("oor_err1", {31'd0, err1}, 32'd1);
    chk("oor_rvalid1", {31'd0, rvalid1}, 32'd1);
    @(posedge clk); #1;
    p0_xfer(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("oor_addr0_intact", rdata0, init_word(0));
    @(posedge clk); #1;

    // Read-after-write across ports
    fork
      p0_xfer(1'b1, 32'd10, 32'hA5A5A5A5);
      begin @(posedge clk); #1; p1_xfer(1'b0, 32'd10, 32'd0); end
    join
    @(negedge clk);
    chk("raw_rdata1", rdata1, 32'hA5A5A5A5);
    @(posedge clk); #1;

    // Concurrent random traffic on both ports
    fork
      for (int i = 0; i < 150; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        p0_xfer(1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      end
      for (int i = 0; i < 80; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        p1_xfer(1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      end
    join
    repeat (2) begin @(posedge clk); #1; end

    // Asynchronous reset while a port 1 response is visible
    p1_xfer(1'b1, 32'd20, 32'hCAFEF00D);
    @(posedge clk); #1;
    p1_xfer(1'b0, 32'd20, 32'd0);
    chk("pre_rst_rvalid1", {31'd0, rvalid1}, 32'd1);
    chk("pre_rst_rdata1", rdata1, 32'hCAFEF00D);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("async_rst_rdata1", rdata1, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wait_cnt", {28'd0, dbg_wait_cnt}, 32'd0);
    @(posedge clk); #1;
    p0_xfer(1'b0, 32'd20, 32'd0);
    repeat (3) begin @(posedge clk); #1; end

    chk("exp0_q_drained", 32'(exp0_q.size()), 32'd0);
    chk("exp1_q_drained", 32'(exp1_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
